// File: rtl/int_div_seq.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Optional `INT_DIV_EARLY_OUT_EN: divide-by-zero, signed overflow and divisor>dividend skip CALC.
module int_div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             kill,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic [1:0]       state_dbg
);

  // Handshake: a request is accepted on a rising edge where start=1, kill=0 and busy=0;
  // the answer appears on result with a one-cycle valid pulse, and busy falls with it.
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  logic [1:0]       state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             is_rem, neg_q, neg_r, div_zero, ovf;

  logic             accept;
  logic             in_signed, in_div_zero, in_ovf, in_early;
  logic [WIDTH-1:0] in_dvd_mag, in_dvs_mag;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] quo_s, rem_s, fix_val;

  assign accept      = (state == S_IDLE) && start && !kill;
  assign in_signed   = ~op[0];
  assign in_dvd_mag  = (in_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign in_dvs_mag  = (in_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
  assign in_div_zero = (divisor == '0);
  assign in_ovf      = in_signed && (dividend == MIN_NEG) && (divisor == '1);

`ifdef INT_DIV_EARLY_OUT_EN
  assign in_early = in_div_zero || in_ovf || (in_dvs_mag > in_dvd_mag);
`else
  assign in_early = 1'b0;
`endif

  assign rem_sh = {rem[WIDTH-1:0], quo[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_mag};

  assign quo_s = neg_q ? -quo : quo;
  assign rem_s = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];

  // RISC-V defines results for x/0 and MIN/-1 instead of trapping.
  always_comb begin
    fix_val = is_rem ? rem_s : quo_s;
    if (div_zero)
      fix_val = is_rem ? dvd_raw : '1;
    else if (ovf)
      fix_val = is_rem ? '0 : dvd_raw;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = in_early ? S_FIX : S_CALC;
      S_CALC:  if (cnt == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs_mag  <= '0;
      dvd_raw  <= '0;
      is_rem   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div_zero <= 1'b0;
      ovf      <= 1'b0;
      result   <= '0;
    end else begin
      if (accept) begin
        is_rem   <= op[1];
        neg_q    <= in_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
        neg_r    <= in_signed && dividend[WIDTH-1];
        div_zero <= in_div_zero;
        ovf      <= in_ovf;
        dvd_raw  <= dividend;
        dvs_mag  <= in_dvs_mag;
        cnt      <= CNT_LOAD;
        // Early-out preloads the final quotient/remainder magnitudes.
        if (in_early) begin
          quo <= '0;
          rem <= {1'b0, in_dvd_mag};
        end else begin
          quo <= in_dvd_mag;
          rem <= '0;
        end
      end else if (state == S_CALC) begin
        if (!trial[WIDTH]) begin
          rem <= trial;
          quo <= {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem <= rem_sh;
          quo <= {quo[WIDTH-2:0], 1'b0};
        end
        if (cnt != '0) cnt <= cnt - 1'b1;
      end else if (state == S_FIX && !kill) begin
        result <= fix_val;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign valid     = (state == S_DONE);
  assign state_dbg = state;

endmodule

// File: tb/tb_int_div_seq.sv
// Self-checking bench for int_div_seq: directed, random, kill, held-start and mid-op reset scenarios.
module tb_int_div_seq;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset, start, kill;
  logic [1:0]   op;
  logic [W-1:0] dividend, divisor;
  logic         busy, valid;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [1:0]   o;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
  } vec_t;

  int_div_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .kill(kill), .op(op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .valid(valid),
    .result(result), .state_dbg(state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: plain 64-bit integer arithmetic, RISC-V divide-by-zero rule.
  function automatic logic [W-1:0] ref_div(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint q, r, sa, sb;
    if (b == '0) return o[1] ? a : '1;
    if (o[0]) begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    q = sa / sb;
    r = sa % sb;
    return o[1] ? r[W-1:0] : q[W-1:0];
  endfunction

  function automatic int exp_lat(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef INT_DIV_EARLY_OUT_EN
    longint ma, mb;
    ma = o[0] ? longint'({32'b0, a}) : longint'($signed(a));
    mb = o[0] ? longint'({32'b0, b}) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b == '0 || mb > ma || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 2;
`endif
    return W + 2;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return W'($urandom_range(0, 20));
      1: return '0;
      2: return 32'h8000_0000;
      3: return '1;
      4: return -W'($urandom_range(1, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // driver task: one full transaction, measuring latency and busy length
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat, output int busy_cycles,
                        output bit timed_out, output bit tail_ok);
    int cycles;
    for (int i = 0; i < 100 && busy; i++) @(posedge clk);
    @(negedge clk);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    op = 2'($urandom); dividend = W'($urandom); divisor = W'($urandom);
    cycles = 0; busy_cycles = 0; timed_out = 1'b1; res = 'x; lat = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy) busy_cycles++;
      if (valid) begin
        timed_out = 1'b0;
        res = result;
        lat = cycles + 1;
        break;
      end
      @(posedge clk);
      #1;
      cycles++;
    end
    @(posedge clk);
    #1;
    tail_ok = !valid && !busy;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    vectors += 4;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", busy); end
    if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", valid); end
    if (result !== '0) begin miscompares++; $display("FAIL reset_result: got %h expected 0", result); end
    if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t tv[13];
    logic [W-1:0] res;
    int lat, bc, el;
    bit to, tail;
    tv[0]  = '{2'b01, 32'd100,        32'd7,          32'd14};
    tv[1]  = '{2'b11, 32'd100,        32'd7,          32'd2};
    tv[2]  = '{2'b00, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD};
    tv[3]  = '{2'b10, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF};
    tv[4]  = '{2'b10, 32'd7,          32'hFFFF_FFFE,  32'd1};
    tv[5]  = '{2'b00, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000};
    tv[6]  = '{2'b10, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0};
    tv[7]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF};
    tv[8]  = '{2'b11, 32'd5,          32'd0,          32'd5};
    tv[9]  = '{2'b00, 32'd5,          32'd0,          32'hFFFF_FFFF};
    tv[10] = '{2'b10, 32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB};
    tv[11] = '{2'b01, 32'd3,          32'd10,         32'd0};
    tv[12] = '{2'b10, 32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD};
    foreach (tv[i]) begin
      run_op(tv[i].o, tv[i].a, tv[i].b, res, lat, bc, to, tail);
      el = exp_lat(tv[i].o, tv[i].a, tv[i].b);
      vectors += 4;
      if (to || res !== tv[i].e) begin
        miscompares++;
        $display("FAIL dir_result[%0d]: got %h expected %h (timeout=%0b)", i, res, tv[i].e, to);
      end
      if (lat !== el) begin miscompares++; $display("FAIL dir_latency[%0d]: got %0d expected %0d", i, lat, el); end
      if (bc !== el) begin miscompares++; $display("FAIL dir_busy_len[%0d]: got %0d expected %0d", i, bc, el); end
      if (!tail) begin miscompares++; $display("FAIL dir_pulse[%0d]: valid/busy still high after pulse", i); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, res, e;
    logic [1:0] o;
    int lat, bc, el;
    bit to, tail;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom); a = pick(); b = pick();
      run_op(o, a, b, res, lat, bc, to, tail);
      e = ref_div(o, a, b);
      el = exp_lat(o, a, b);
      vectors += 2;
      if (to || res !== e) begin
        miscompares++;
        $display("FAIL rand_result: op=%0d a=%h b=%h got %h expected %h", o, a, b, res, e);
      end
      if (lat !== el || !tail) begin
        miscompares++;
        $display("FAIL rand_timing: op=%0d latency got %0d expected %0d tail_ok=%0b", o, lat, el, tail);
      end
    end
  endtask

  task automatic test_kill();
    logic [W-1:0] res, prior;
    int lat, bc;
    bit to, tail, seen;
    run_op(2'b01, 32'd1000, 32'd3, prior, lat, bc, to, tail);
    vectors++;
    if (prior !== 32'd333) begin miscompares++; $display("FAIL kill_setup: got %h expected %h", prior, 32'd333); end
    // abort at accept+10
    @(negedge clk);
    op = 2'b00; dividend = 32'd12345; divisor = 32'hFFFF_FFF9; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    vectors += 2;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL kill_busy: got %b expected 0", busy); end
    if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL kill_state: got %0d expected 0", state_dbg); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    vectors += 2;
    if (seen) begin miscompares++; $display("FAIL kill_no_valid: got valid=1 expected none"); end
    if (result !== prior) begin miscompares++; $display("FAIL kill_result_hold: got %h expected %h", result, prior); end
    // kill and start together in IDLE: start dropped
    @(negedge clk);
    op = 2'b01; dividend = 32'd50; divisor = 32'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; kill = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL kill_start_same: got busy=%b expected 0", busy); end
    run_op(2'b10, 32'hFFFF_FF9C, 32'd7, res, lat, bc, to, tail);
    vectors++;
    if (to || res !== ref_div(2'b10, 32'hFFFF_FF9C, 32'd7)) begin
      miscompares++;
      $display("FAIL kill_after: got %h expected %h", res, ref_div(2'b10, 32'hFFFF_FF9C, 32'd7));
    end
  endtask

  // start held high with operands changing every cycle; scoreboard keyed on accepts
  task automatic test_back_to_back();
    int mcnt, accepts, results;
    logic [W-1:0] e;
    exp_q.delete();
    mcnt = 0; accepts = 0; results = 0;
    for (int cyc = 0; cyc < 220; cyc++) begin
      @(negedge clk);
      start = (cyc < 110);
      op = 2'($urandom); dividend = pick(); divisor = pick();
      if (start && mcnt == 0) begin
        exp_q.push_back(ref_div(op, dividend, divisor));
        mcnt = exp_lat(op, dividend, divisor) + 1;
        accepts++;
      end
      @(posedge clk);
      #1;
      if (mcnt > 0) mcnt--;
      vectors++;
      if (busy !== (mcnt != 0) || valid !== (mcnt == 1)) begin
        miscompares++;
        $display("FAIL b2b_handshake: cyc %0d got busy=%b valid=%b expected busy=%b valid=%b",
                 cyc, busy, valid, (mcnt != 0), (mcnt == 1));
      end
      if (valid) begin
        results++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        vectors++;
        if (result !== e) begin miscompares++; $display("FAIL b2b_result: got %h expected %h", result, e); end
      end
    end
    start = 1'b0;
    vectors += 2;
    if (exp_q.size() != 0 || results != accepts) begin
      miscompares++;
      $display("FAIL b2b_count: got %0d results expected %0d", results, accepts);
    end
    if (accepts < 3) begin miscompares++; $display("FAIL b2b_accepts: got %0d expected >=3", accepts); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] res;
    int lat, bc;
    bit to, tail, seen;
    @(negedge clk);
    op = 2'b01; dividend = 32'd999; divisor = 32'd4; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    vectors += 4;
    if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    if (valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_valid: got %b expected 0", valid); end
    if (result !== '0) begin miscompares++; $display("FAIL rst_mid_result: got %h expected 0", result); end
    if (state_dbg !== 2'd0) begin miscompares++; $display("FAIL rst_mid_state: got %0d expected 0", state_dbg); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) seen = 1'b1;
    end
    vectors += 2;
    if (seen) begin miscompares++; $display("FAIL rst_mid_spurious: got activity after reset expected none"); end
    if (result !== '0) begin miscompares++; $display("FAIL rst_mid_hold: got %h expected 0", result); end
    run_op(2'b00, 32'hFFFF_FC18, 32'd7, res, lat, bc, to, tail);
    vectors++;
    if (to || res !== ref_div(2'b00, 32'hFFFF_FC18, 32'd7)) begin
      miscompares++;
      $display("FAIL rst_mid_after: got %h expected %h", res, ref_div(2'b00, 32'hFFFF_FC18, 32'd7));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
